// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, sideband type and saturating helpers for the MAC bank
package mac_pkg;

  localparam int NUM_MAC_DEF = 12;
  localparam int KSZ_DEF     = 9;
  localparam int AW_DEF      = 8;
  localparam int WW_DEF      = 8;
  localparam int BIAS_W_DEF  = 16;
  localparam int ACC_W_DEF   = 32;
  localparam int OUT_W_DEF   = 8;

  typedef struct packed {
    logic       vld;
    logic       last;
    logic       relu;
    logic [4:0] shift;
  } side_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Number of adder-tree nodes at a given level (odd leftovers carried up).
  function automatic int node_cnt(input int n, input int lvl);
    return (n + (1 << lvl) - 1) >> lvl;
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w, output logic ovf);
    logic signed [63:0] s, hi, lo;
    s   = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    ovf = 1'b0;
    if (s > hi) begin
      s   = hi;
      ovf = 1'b1;
    end else if (s < lo) begin
      s   = lo;
      ovf = 1'b1;
    end
    return s;
  endfunction

  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mac_bank_acc_if.sv
// rtl/mac_bank_acc_if.sv - beat input and result bus of the MAC bank
interface mac_bank_acc_if import mac_pkg::*; #(
  parameter int NUM_MAC = NUM_MAC_DEF,
  parameter int KSZ     = KSZ_DEF,
  parameter int AW      = AW_DEF,
  parameter int WW      = WW_DEF,
  parameter int BIAS_W  = BIAS_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
);
  logic                          vld_i;
  logic                          last_i;
  logic [NUM_MAC*KSZ*AW-1:0]     din_i;
  logic [NUM_MAC*KSZ*WW-1:0]     wgt_i;
  logic signed [BIAS_W-1:0]      bias_i;
  logic [4:0]                    cfg_shift_i;
  logic                          cfg_relu_i;
  logic                          vld_o;
  logic signed [OUT_W-1:0]       dout_o;
  logic signed [ACC_W-1:0]       acc_o;
  logic                          ovf_o;
  logic                          busy_o;

  modport master (
    output vld_i, last_i, din_i, wgt_i, bias_i, cfg_shift_i, cfg_relu_i,
    input  vld_o, dout_o, acc_o, ovf_o, busy_o
  );

  modport slave (
    input  vld_i, last_i, din_i, wgt_i, bias_i, cfg_shift_i, cfg_relu_i,
    output vld_o, dout_o, acc_o, ovf_o, busy_o
  );
endinterface

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - KSZ-tap signed dot product, products then sum registered
module mac_lane import mac_pkg::*; #(
  parameter int KSZ = KSZ_DEF,
  parameter int AW  = AW_DEF,
  parameter int WW  = WW_DEF,
  localparam int PROD_W = AW + WW + clog2(KSZ)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [KSZ*AW-1:0]        din,
  input  logic [KSZ*WW-1:0]        wgt,
  output logic signed [PROD_W-1:0] sum
);
  logic signed [AW+WW-1:0] prod [KSZ];
  logic signed [PROD_W-1:0] tapSum;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < KSZ; k++) prod[k] <= '0;
      sum <= '0;
    end else begin
      for (int k = 0; k < KSZ; k++)
        prod[k] <= (AW+WW)'($signed(din[k*AW +: AW])) * (AW+WW)'($signed(wgt[k*WW +: WW]));
      sum <= tapSum;
    end
  end

  always_comb begin
    tapSum = '0;
    for (int k = 0; k < KSZ; k++) tapSum = tapSum + PROD_W'(prod[k]);
  end
endmodule

// File: rtl/mac_bank_acc.sv
// rtl/mac_bank_acc.sv - lane bank, registered adder tree, saturating group accumulator, post-process
module mac_bank_acc import mac_pkg::*; #(
  parameter int NUM_MAC = NUM_MAC_DEF,
  parameter int KSZ     = KSZ_DEF,
  parameter int AW      = AW_DEF,
  parameter int WW      = WW_DEF,
  parameter int BIAS_W  = BIAS_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  localparam int PROD_W   = AW + WW + clog2(KSZ),
  localparam int SUM_W    = PROD_W + clog2(NUM_MAC),
  localparam int TREE_LAT = clog2(NUM_MAC),
  localparam int SB_LAT   = 2 + TREE_LAT,
  localparam int LAT      = SB_LAT + 2,
  localparam int RW       = ACC_W + 1,
  localparam int CNT_W    = clog2(LAT + 1) + 1
) (
  input  logic           clk,
  input  logic           rstn,
  mac_bank_acc_if.slave  bus
);
  logic signed [PROD_W-1:0] laneSum [NUM_MAC];

  for (genvar m = 0; m < NUM_MAC; m++) begin : g_lane
    mac_lane #(.KSZ(KSZ), .AW(AW), .WW(WW)) u_lane (
      .clk  (clk),
      .rstn (rstn),
      .din  (bus.din_i[m*KSZ*AW +: KSZ*AW]),
      .wgt  (bus.wgt_i[m*KSZ*WW +: KSZ*WW]),
      .sum  (laneSum[m])
    );
  end

  for (genvar l = 0; l <= TREE_LAT; l++) begin : g_lvl
    localparam int N = node_cnt(NUM_MAC, l);
    logic signed [SUM_W-1:0] node [N];
    if (l == 0) begin : g_leaf
      always_comb begin
        for (int i = 0; i < N; i++) node[i] = SUM_W'(laneSum[i]);
      end
    end else begin : g_add
      localparam int NP = node_cnt(NUM_MAC, l - 1);
      for (genvar i = 0; i < N; i++) begin : g_node
        if (2*i + 1 < NP) begin : g_pair
          always_ff @(posedge clk) node[i] <= g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
        end else begin : g_pass
          always_ff @(posedge clk) node[i] <= g_lvl[l-1].node[2*i];
        end
      end
    end
  end

  logic signed [SUM_W-1:0] treeOut;
  assign treeOut = g_lvl[TREE_LAT].node[0];

  // Sideband rides alongside the data so it lines up with the tree output.
  side_t                    side     [SB_LAT];
  logic signed [BIAS_W-1:0] sideBias [SB_LAT];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < SB_LAT; i++) side[i] <= '0;
    end else begin
      side[0] <= '{vld: bus.vld_i, last: bus.last_i, relu: bus.cfg_relu_i, shift: bus.cfg_shift_i};
      for (int i = 1; i < SB_LAT; i++) side[i] <= side[i-1];
    end
  end

  always_ff @(posedge clk) begin
    sideBias[0] <= bus.bias_i;
    for (int i = 1; i < SB_LAT; i++) sideBias[i] <= sideBias[i-1];
  end

  side_t                   sbOut;
  logic signed [ACC_W-1:0] acc, accSum, accBias, postV;
  logic                    ovfSum, ovfBias, groupOpen, postVld, postRelu;
  logic [4:0]              postShift;

  assign sbOut = side[SB_LAT-1];

  always_comb begin
    accSum  = ACC_W'(sat_add(groupOpen ? 64'(acc) : 64'sd0, 64'(treeOut), ACC_W, ovfSum));
    accBias = ACC_W'(sat_add(64'(accSum), 64'(sideBias[SB_LAT-1]), ACC_W, ovfBias));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc       <= '0;
      groupOpen <= 1'b0;
      postVld   <= 1'b0;
      postV     <= '0;
      postShift <= '0;
      postRelu  <= 1'b0;
      bus.ovf_o <= 1'b0;
    end else begin
      postVld <= sbOut.vld && sbOut.last;
      if (sbOut.vld) begin
        if (sbOut.last) begin
          postV     <= accBias;
          postShift <= sbOut.shift;
          postRelu  <= sbOut.relu;
          groupOpen <= 1'b0;
          bus.ovf_o <= bus.ovf_o | ovfSum | ovfBias;
        end else begin
          acc       <= accSum;
          groupOpen <= 1'b1;
          bus.ovf_o <= bus.ovf_o | ovfSum;
        end
      end
    end
  end

  logic signed [RW-1:0]    postR;
  logic signed [OUT_W-1:0] postDout;

  always_comb begin
    postR = RW'(postV);
    if (postShift != 5'd0) postR = (postR + (RW'(1) <<< (postShift - 5'd1))) >>> postShift;
    if (postRelu && postR < 0) postR = '0;
    postDout = OUT_W'(sat_narrow(64'(postR), OUT_W));
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.vld_o  <= 1'b0;
      bus.dout_o <= '0;
      bus.acc_o  <= '0;
    end else begin
      bus.vld_o <= postVld;
      if (postVld) begin
        bus.dout_o <= postDout;
        bus.acc_o  <= postV;
      end
    end
  end

  // Groups in flight: opened at the input, retired when their vld_o is launched.
  logic             inOpen, groupStart;
  logic [CNT_W-1:0] pending, pendingNext;

  assign groupStart = bus.vld_i && !inOpen;

  always_comb begin
    pendingNext = pending + CNT_W'(groupStart) - CNT_W'(postVld);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      inOpen     <= 1'b0;
      pending    <= '0;
      bus.busy_o <= 1'b0;
    end else begin
      if (bus.vld_i) inOpen <= !bus.last_i;
      pending    <= pendingNext;
      bus.busy_o <= (pendingNext != '0);
    end
  end
endmodule

// File: tb/tb_mac_bank_acc.sv
// tb/tb_mac_bank_acc.sv - scoreboard bench for mac_bank_acc (32- and 24-bit accumulator builds)
module tb_mac_bank_acc;
  import mac_pkg::*;

  localparam int NM  = 12;
  localparam int K   = 9;
  localparam int LAT = 8;

  typedef struct {
    longint acc;
    longint dout;
    int     cyc;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mac_bank_acc_if #(.ACC_W(32)) bus0 ();
  mac_bank_acc_if #(.ACC_W(24)) bus1 ();

  mac_bank_acc #(.ACC_W(32)) dut   (.clk(clk), .rstn(rstn), .bus(bus0));
  mac_bank_acc #(.ACC_W(24)) dut24 (.clk(clk), .rstn(rstn), .bus(bus1));

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  bit   ovfExp [2];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int actOf(input int a, input bit ramp, input int m, input int k);
    return ramp ? a + k - 4 : a;
  endfunction

  function automatic int wgtOf(input int w, input bit ramp, input int m, input int k);
    return ramp ? w + (m % 5) - 2 : w;
  endfunction

  function automatic void model(input int accW, input int a, input int w, input int nb,
                                input bit ramp, input int bias, input int sh, input bit relu,
                                output longint accE, output longint doutE, output bit ovf);
    longint hi, lo, beat, s, r;
    hi = (longint'(1) <<< (accW - 1)) - 1;
    lo = -hi - 1;
    beat = 0;
    s = 0;
    ovf = 1'b0;
    for (int m = 0; m < NM; m++)
      for (int k = 0; k < K; k++)
        beat += longint'(actOf(a, ramp, m, k) * wgtOf(w, ramp, m, k));
    for (int b = 0; b <= nb; b++) begin
      s += (b < nb) ? beat : longint'(bias);
      if (s > hi) begin s = hi; ovf = 1'b1; end
      else if (s < lo) begin s = lo; ovf = 1'b1; end
    end
    accE = s;
    r = (sh == 0) ? s : (s + (longint'(1) <<< (sh - 1))) >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    doutE = r;
  endfunction

  task automatic drive(input int sel, input bit v, input bit last, input int a, input int w,
                       input bit ramp, input int bias, input int sh, input bit relu);
    logic [NM*K*8-1:0] d, g;
    for (int m = 0; m < NM; m++)
      for (int k = 0; k < K; k++) begin
        d[(m*K+k)*8 +: 8] = 8'(actOf(a, ramp, m, k));
        g[(m*K+k)*8 +: 8] = 8'(wgtOf(w, ramp, m, k));
      end
    if (sel == 0) begin
      bus0.vld_i = v; bus0.last_i = last; bus0.din_i = d; bus0.wgt_i = g;
      bus0.bias_i = 16'(bias); bus0.cfg_shift_i = 5'(sh); bus0.cfg_relu_i = relu;
    end else begin
      bus1.vld_i = v; bus1.last_i = last; bus1.din_i = d; bus1.wgt_i = g;
      bus1.bias_i = 16'(bias); bus1.cfg_shift_i = 5'(sh); bus1.cfg_relu_i = relu;
    end
  endtask

  task automatic runGroup(input int sel, input int a, input int w, input int nb, input int gap,
                          input bit ramp, input int bias, input int sh, input bit relu);
    exp_t   e;
    longint ea, ed;
    bit     o;
    model(sel ? 24 : 32, a, w, nb, ramp, bias, sh, relu, ea, ed, o);
    ovfExp[sel] |= o;
    for (int b = 0; b < nb; b++) begin
      drive(sel, 1'b1, b == nb - 1, a, w, ramp, bias, sh, relu);
      if (b == nb - 1) begin
        e.acc = ea; e.dout = ed; e.cyc = cyc + LAT;
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
      end
      @(posedge clk); #1;
      drive(sel, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
      if (b < nb - 1) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain pending results", q0.size() + q1.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rstn && bus0.vld_o === 1'b1) begin
      if (q0.size() == 0) chk("unexpected vld_o dut32 queue size", q0.size(), 1);
      else begin
        e0 = q0.pop_front();
        chk("acc_o dut32", $signed(bus0.acc_o), e0.acc);
        chk("dout_o dut32", $signed(bus0.dout_o), e0.dout);
        chk("latency dut32", cyc, e0.cyc);
        chk("busy_o with vld_o dut32", bus0.busy_o, q0.size() != 0);
      end
    end
    if (rstn && bus1.vld_o === 1'b1) begin
      if (q1.size() == 0) chk("unexpected vld_o dut24 queue size", q1.size(), 1);
      else begin
        e1 = q1.pop_front();
        chk("acc_o dut24", $signed(bus1.acc_o), e1.acc);
        chk("dout_o dut24", $signed(bus1.dout_o), e1.dout);
        chk("latency dut24", cyc, e1.cyc);
        chk("busy_o with vld_o dut24", bus1.busy_o, q1.size() != 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset vld_o", bus0.vld_o, 0);
    chk("reset dout_o", bus0.dout_o, 0);
    chk("reset acc_o", bus0.acc_o, 0);
    chk("reset ovf_o", bus0.ovf_o, 0);
    chk("reset busy_o", bus0.busy_o, 0);
    chk("reset ovf_o dut24", bus1.ovf_o, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    runGroup(0, 1, 1, 1, 0, 1'b0, 0, 0, 1'b0);
    chk("busy_o rise", bus0.busy_o, 1);
    drain();
    chk("busy_o idle", bus0.busy_o, 0);

    runGroup(0, 2, 3, 3, 2, 1'b0, -200, 4, 1'b0);
    drain();

    runGroup(0, -1, 1, 1, 0, 1'b0, 0, 0, 1'b0);
    drain();
    runGroup(0, -1, 1, 1, 0, 1'b0, 0, 0, 1'b1);
    drain();

    runGroup(0, 127, 127, 1, 0, 1'b0, 0, 0, 1'b0);
    runGroup(0, -128, 127, 1, 0, 1'b0, 0, 0, 1'b0);
    drain();

    runGroup(0, 3, 2, 2, 1, 1'b1, 50, 3, 1'b1);
    drain();

    runGroup(0, 1, 1, 1, 0, 1'b0, 0, 0, 1'b0);
    runGroup(0, 2, 1, 1, 0, 1'b0, 7, 1, 1'b0);
    runGroup(0, -1, 1, 1, 0, 1'b0, 0, 0, 1'b1);
    drain();
    chk("ovf_o dut32 clear", bus0.ovf_o, ovfExp[0]);

    runGroup(1, -128, -128, 5, 0, 1'b0, 0, 0, 1'b0);
    drain();
    chk("ovf_o set", bus1.ovf_o, 1);
    runGroup(1, 1, 1, 1, 0, 1'b0, 0, 0, 1'b0);
    drain();
    chk("ovf_o sticky", bus1.ovf_o, 1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    ovfExp[0] = 1'b0;
    ovfExp[1] = 1'b0;
    chk("ovf_o after reset", bus1.ovf_o, 0);

    for (int b = 0; b < 2; b++) begin
      drive(0, 1'b1, 1'b0, 1, 1, 1'b0, 0, 0, 1'b0);
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("busy_o after abort", bus0.busy_o, 0);
    runGroup(0, 1, 1, 1, 0, 1'b0, 0, 0, 1'b0);
    drain();
    repeat (12) @(posedge clk);
    #1;
    chk("final queue dut32", q0.size(), 0);
    chk("final queue dut24", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
